vga_scan_ctrl: RTL and testbench
================================

VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 Parameter H_TOTAL, default 800, pixels per line (0..H_TOTAL-1).
REQ-002 Parameter V_TOTAL, default 525, lines per frame (0..V_TOTAL-1).
REQ-003 Parameter V_ACTIVE, default 480, first line of vertical blank.
REQ-004 Parameter DIV, default 4, clk cycles per pixel (100 MHz clk to 25 MHz pixel rate).
REQ-005 clk  in  1  system clock; all state changes on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 en  in  1  scan enable; low = scan halted and counters cleared.
REQ-008 upd_done  in  1  game-logic pulse: frame update finished.
REQ-009 ovr_clr  in  1  clears sticky overrun flag.
REQ-010 H  out  15  horizontal pixel counter, drives sync decoder.
REQ-011 V  out  15  vertical line counter, drives sync decoder.
REQ-012 pix_ce  out  1  one-clk pixel strobe, high when divider = DIV-1 and en = 1.
REQ-013 upd_req  out  1  level request to game logic: update window open.
REQ-014 overrun  out  1  sticky: game update missed its vblank window.
REQ-015 frame_cnt  out  16  completed-frame count, wraps 65535 -> 0.

Function
REQ-016 Divider counts 0..DIV-1 on every clk while en = 1, wraps to 0 after DIV-1.
REQ-017 On a clk with pix_ce = 1: H increments; H = H_TOTAL-1 wraps to 0 and V increments; V = V_TOTAL-1 with that H wrap sets V to 0 and increments frame_cnt.
REQ-018 H, V and frame_cnt hold on clk without pix_ce; all outputs are registered except pix_ce (decoded from divider register).
REQ-019 en = 0 on any clk: next cycle divider, H, V = 0, FSM = SCAN, upd_req = 0; frame_cnt and overrun hold.
REQ-020 FSM states: SCAN, REQ, HOLD.
REQ-021 SCAN -> REQ when pix_ce = 1, H = H_TOTAL-1 and V = V_ACTIVE-1 (entry to vblank); upd_req = 1 from the next clk.
REQ-022 REQ -> HOLD on upd_done = 1; upd_req = 0 from the next clk.
REQ-023 REQ or HOLD -> SCAN on the pix_ce clk that wraps V to 0.
REQ-024 In REQ at the V-wrap clk: overrun set to 1, upd_req dropped, state = SCAN.
REQ-025 upd_done and V-wrap on the same clk in REQ: done wins, no overrun, state = SCAN.
REQ-026 upd_done ignored in SCAN and HOLD.
REQ-027 ovr_clr = 1 clears overrun next clk; simultaneous set and clear: set wins.
REQ-028 Counter arithmetic is unsigned 15-bit; H never exceeds H_TOTAL-1, V never exceeds V_TOTAL-1.

Reset
REQ-029 rst_n = 0 asynchronously forces H = 0, V = 0, divider = 0, pix_ce = 0, upd_req = 0, overrun = 0, frame_cnt = 0, FSM = SCAN.
REQ-030 Reset mid-frame or mid-handshake abandons the request without setting overrun.
REQ-031 First pix_ce after release with en = 1 occurs on the DIV-th rising edge.

Structure
REQ-032 Shared package vga_pkg holds H_TOTAL, V_TOTAL, H_ACTIVE = 640, V_ACTIVE, DIV and the FSM state enumeration.
REQ-033 One sub-module, pix_div (divider producing pix_ce); counters and FSM stay in vga_scan_ctrl.

Verification
REQ-034 Reset release, en = 1, 4*800 clk -> pix_ce every 4th clk; H 0..799 then H = 0, V = 1.
REQ-035 Run to H = 799, V = 479 pix_ce -> upd_req = 1 next clk; upd_done at V = 490 -> upd_req = 0, HOLD, overrun = 0.
REQ-036 No upd_done through V = 524, H = 799 -> overrun = 1, upd_req = 0, V = 0; ovr_clr pulse -> overrun = 0.
REQ-037 upd_done on the V-wrap clk -> overrun = 0, frame_cnt +1, state SCAN.
REQ-038 en = 0 at H = 300, V = 200 -> H = 0, V = 0 next clk, pix_ce = 0, frame_cnt unchanged; rst_n = 0 during REQ -> all outputs 0 immediately.
REQ-039 Preload to 65535 completed frames, complete one more -> frame_cnt = 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing constants and scan FSM encoding for the VGA scan controller.
package vga_pkg;

  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_TOTAL  = 525;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned DIV      = 4;

  localparam int unsigned CNT_W    = 15;
  localparam int unsigned FRAME_W  = 16;

  typedef enum logic [1:0] {
    ST_SCAN = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/vga_scan_ctrl_pix_div.sv
// Clock divider: free-running 0..DIV-1 count, pix_ce decoded from the count register.
module pix_div #(
  parameter int unsigned DIV = vga_pkg::DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic pix_ce
);

  localparam int unsigned     DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] r_div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (!en || (r_div == DIV_LAST)) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign pix_ce = en && (r_div == DIV_LAST);

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA raster scan counters plus the vblank update-window handshake with game logic.
module vga_scan_ctrl #(
  parameter int unsigned H_TOTAL  = vga_pkg::H_TOTAL,
  parameter int unsigned V_TOTAL  = vga_pkg::V_TOTAL,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned DIV      = vga_pkg::DIV
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        upd_done,
  input  logic                        ovr_clr,
  output logic [vga_pkg::CNT_W-1:0]   H,
  output logic [vga_pkg::CNT_W-1:0]   V,
  output logic                        pix_ce,
  output logic                        upd_req,
  output logic                        overrun,
  output logic [vga_pkg::FRAME_W-1:0] frame_cnt
);

  import vga_pkg::*;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ENTRY = CNT_W'(V_ACTIVE - 1);

  logic [CNT_W-1:0]   r_h;
  logic [CNT_W-1:0]   r_v;
  logic [FRAME_W-1:0] r_frame;
  logic               r_upd_req;
  logic               r_overrun;
  state_t             r_state;

  state_t             w_state_nxt;
  logic               w_ovr_set;
  logic               w_pix_ce;
  logic               w_h_last;
  logic               w_v_wrap;
  logic               w_vblank_entry;

  pix_div #(.DIV(DIV)) u_pix_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .pix_ce (w_pix_ce)
  );

  assign w_h_last       = (r_h == H_LAST);
  assign w_v_wrap       = w_pix_ce && w_h_last && (r_v == V_LAST);
  assign w_vblank_entry = w_pix_ce && w_h_last && (r_v == V_ENTRY);

  // Raster position; en low parks the beam at the origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (!en) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_pix_ce) begin
      if (w_h_last) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? '0 : r_v + CNT_W'(1);
      end else begin
        r_h <= r_h + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_SCAN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A done arriving on the wrap clock still counts as on time.
  always_comb begin
    w_state_nxt = r_state;
    w_ovr_set   = 1'b0;
    if (!en) begin
      w_state_nxt = ST_SCAN;
    end else begin
      case (r_state)
        ST_SCAN: if (w_vblank_entry) w_state_nxt = ST_REQ;
        ST_REQ: begin
          if (w_v_wrap) begin
            w_state_nxt = ST_SCAN;
            w_ovr_set   = !upd_done;
          end else if (upd_done) begin
            w_state_nxt = ST_HOLD;
          end
        end
        ST_HOLD: if (w_v_wrap) w_state_nxt = ST_SCAN;
        default: w_state_nxt = ST_SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_upd_req <= 1'b0;
      r_overrun <= 1'b0;
      r_frame   <= '0;
    end else begin
      r_upd_req <= (w_state_nxt == ST_REQ);
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr) begin
        r_overrun <= 1'b0;
      end
      if (w_v_wrap) begin
        r_frame <= r_frame + FRAME_W'(1);
      end
    end
  end

  assign H         = r_h;
  assign V         = r_v;
  assign pix_ce    = w_pix_ce;
  assign upd_req   = r_upd_req;
  assign overrun   = r_overrun;
  assign frame_cnt = r_frame;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl using a shrunken raster (10x8, vblank at line 5, DIV 4).
module tb_vga_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        upd_done;
  logic        ovr_clr;
  logic [14:0] h;
  logic [14:0] v;
  logic        pix_ce;
  logic        upd_req;
  logic        overrun;
  logic [15:0] frame_cnt;

  logic        en2;
  logic [14:0] h2;
  logic [14:0] v2;
  logic        pix_ce2;
  logic        upd_req2;
  logic        overrun2;
  logic [15:0] frame2;

  int vectors;
  int miscompares;
  int k;

  vga_scan_ctrl #(.H_TOTAL(10), .V_TOTAL(8), .V_ACTIVE(5), .DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .upd_done  (upd_done),
    .ovr_clr   (ovr_clr),
    .H         (h),
    .V         (v),
    .pix_ce    (pix_ce),
    .upd_req   (upd_req),
    .overrun   (overrun),
    .frame_cnt (frame_cnt)
  );

  // One-pixel frame at one clk per pixel: a frame completes every enabled clock.
  vga_scan_ctrl #(.H_TOTAL(1), .V_TOTAL(1), .V_ACTIVE(1), .DIV(1)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en2),
    .upd_done  (1'b0),
    .ovr_clr   (1'b0),
    .H         (h2),
    .V         (v2),
    .pix_ce    (pix_ce2),
    .upd_req   (upd_req2),
    .overrun   (overrun2),
    .frame_cnt (frame2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    k = k + 1;
  endtask

  task automatic run_to(input int t);
    while (k < t) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; en2 = 1'b0; upd_done = 1'b0; ovr_clr = 1'b0; k = 0;
    @(negedge clk);
    en = 1'b1;
    tick(); tick();
    vectors++;
    if ({h, v} !== 30'd0) begin
      miscompares++; $display("FAIL reset_hv: got h=%0d v=%0d expected 0 0", h, v);
    end
    vectors++;
    if ({pix_ce, upd_req, overrun} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags: got %b expected 000", {pix_ce, upd_req, overrun});
    end
    vectors++;
    if (frame_cnt !== 16'd0) begin
      miscompares++; $display("FAIL reset_frame: got %0d expected 0", frame_cnt);
    end
    rst_n = 1'b1;
    k = 0;
  endtask

  // First line: strobe on every 4th clock, H steps per strobe; a stray done in SCAN is ignored.
  task automatic test_pix_strobe();
    logic        exp_ce;
    logic [14:0] exp_h;
    logic [14:0] exp_v;
    for (int i = 1; i <= 40; i++) begin
      upd_done = (k == 20);
      tick();
      exp_ce = (k % 4) == 3;
      exp_h  = 15'((k / 4) % 10);
      exp_v  = 15'(k / 40);
      vectors++;
      if ({pix_ce, h, v, upd_req} !== {exp_ce, exp_h, exp_v, 1'b0}) begin
        miscompares++;
        $display("FAIL strobe_k%0d: got ce=%b h=%0d v=%0d req=%b expected ce=%b h=%0d v=%0d req=0",
                 k, pix_ce, h, v, upd_req, exp_ce, exp_h, exp_v);
      end
    end
    upd_done = 1'b0;
  endtask

  task automatic test_req_handshake();
    run_to(199);
    vectors++;
    if ({h, v, pix_ce, upd_req} !== {15'd9, 15'd4, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL pre_req: got h=%0d v=%0d ce=%b req=%b expected 9 4 1 0", h, v, pix_ce, upd_req);
    end
    tick();
    vectors++;
    if ({h, v, upd_req} !== {15'd0, 15'd5, 1'b1}) begin
      miscompares++; $display("FAIL req_rise: got h=%0d v=%0d req=%b expected 0 5 1", h, v, upd_req);
    end
    run_to(240);
    vectors++;
    if ({v, upd_req} !== {15'd6, 1'b1}) begin
      miscompares++; $display("FAIL req_held: got v=%0d req=%b expected 6 1", v, upd_req);
    end
    upd_done = 1'b1;
    tick();
    upd_done = 1'b0;
    vectors++;
    if ({upd_req, overrun} !== 2'b00) begin
      miscompares++; $display("FAIL done_ack: got req=%b ovr=%b expected 0 0", upd_req, overrun);
    end
    run_to(320);
    vectors++;
    if ({h, v, frame_cnt, overrun, upd_req} !== {15'd0, 15'd0, 16'd1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL hold_wrap: got h=%0d v=%0d frame=%0d ovr=%b req=%b expected 0 0 1 0 0",
               h, v, frame_cnt, overrun, upd_req);
    end
  endtask

  task automatic test_overrun();
    run_to(520);
    vectors++;
    if ({h, v, upd_req} !== {15'd0, 15'd5, 1'b1}) begin
      miscompares++; $display("FAIL req2_rise: got h=%0d v=%0d req=%b expected 0 5 1", h, v, upd_req);
    end
    run_to(639);
    vectors++;
    if ({h, v, pix_ce, upd_req, overrun} !== {15'd9, 15'd7, 1'b1, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL pre_wrap: got h=%0d v=%0d ce=%b req=%b ovr=%b expected 9 7 1 1 0", h, v, pix_ce, upd_req, overrun);
    end
    tick();
    vectors++;
    if ({h, v, upd_req, overrun, frame_cnt} !== {15'd0, 15'd0, 1'b0, 1'b1, 16'd2}) begin
      miscompares++;
      $display("FAIL ovr_set: got h=%0d v=%0d req=%b ovr=%b frame=%0d expected 0 0 0 1 2",
               h, v, upd_req, overrun, frame_cnt);
    end
    run_to(650);
    vectors++;
    if (overrun !== 1'b1) begin
      miscompares++; $display("FAIL ovr_sticky: got %b expected 1", overrun);
    end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++; $display("FAIL ovr_clr: got %b expected 0", overrun);
    end
    run_to(959);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    vectors++;
    if ({overrun, frame_cnt} !== {1'b1, 16'd3}) begin
      miscompares++; $display("FAIL set_beats_clr: got ovr=%b frame=%0d expected 1 3", overrun, frame_cnt);
    end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++; $display("FAIL ovr_clr2: got %b expected 0", overrun);
    end
  endtask

  task automatic test_done_on_wrap();
    run_to(1160);
    vectors++;
    if (upd_req !== 1'b1) begin
      miscompares++; $display("FAIL req3_rise: got %b expected 1", upd_req);
    end
    run_to(1279);
    upd_done = 1'b1;
    tick();
    upd_done = 1'b0;
    vectors++;
    if ({overrun, upd_req, frame_cnt, v, h} !== {1'b0, 1'b0, 16'd4, 15'd0, 15'd0}) begin
      miscompares++;
      $display("FAIL done_wrap: got ovr=%b req=%b frame=%0d v=%0d h=%0d expected 0 0 4 0 0",
               overrun, upd_req, frame_cnt, v, h);
    end
    run_to(1480);
    vectors++;
    if ({v, upd_req} !== {15'd5, 1'b1}) begin
      miscompares++; $display("FAIL req4_rise: got v=%0d req=%b expected 5 1", v, upd_req);
    end
  endtask

  task automatic test_en_low();
    run_to(1533);
    vectors++;
    if ({h, v, upd_req} !== {15'd3, 15'd6, 1'b1}) begin
      miscompares++; $display("FAIL pre_en_low: got h=%0d v=%0d req=%b expected 3 6 1", h, v, upd_req);
    end
    en = 1'b0;
    tick();
    vectors++;
    if ({h, v, pix_ce, upd_req, frame_cnt} !== {15'd0, 15'd0, 1'b0, 1'b0, 16'd4}) begin
      miscompares++;
      $display("FAIL en_low: got h=%0d v=%0d ce=%b req=%b frame=%0d expected 0 0 0 0 4",
               h, v, pix_ce, upd_req, frame_cnt);
    end
    tick(); tick();
    vectors++;
    if ({h, pix_ce} !== {15'd0, 1'b0}) begin
      miscompares++; $display("FAIL en_low_hold: got h=%0d ce=%b expected 0 0", h, pix_ce);
    end
    en = 1'b1;
    k = 0;
    run_to(3);
    vectors++;
    if ({pix_ce, h} !== {1'b1, 15'd0}) begin
      miscompares++; $display("FAIL en_restart_ce: got ce=%b h=%0d expected 1 0", pix_ce, h);
    end
    tick();
    vectors++;
    if ({pix_ce, h, upd_req} !== {1'b0, 15'd1, 1'b0}) begin
      miscompares++; $display("FAIL en_restart_h: got ce=%b h=%0d req=%b expected 0 1 0", pix_ce, h, upd_req);
    end
  endtask

  task automatic test_reset_mid_req();
    run_to(210);
    vectors++;
    if (upd_req !== 1'b1) begin
      miscompares++; $display("FAIL req5_rise: got %b expected 1", upd_req);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({h, v, pix_ce, upd_req, overrun, frame_cnt} !== 49'd0) begin
      miscompares++;
      $display("FAIL async_reset: got h=%0d v=%0d ce=%b req=%b ovr=%b frame=%0d expected all 0",
               h, v, pix_ce, upd_req, overrun, frame_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    tick();
    vectors++;
    if ({upd_req, overrun} !== 2'b00) begin
      miscompares++; $display("FAIL post_reset: got req=%b ovr=%b expected 0 0", upd_req, overrun);
    end
    run_to(199);
    vectors++;
    if ({h, v, upd_req, overrun, frame_cnt} !== {15'd9, 15'd4, 1'b0, 1'b0, 16'd0}) begin
      miscompares++;
      $display("FAIL post_reset_scan: got h=%0d v=%0d req=%b ovr=%b frame=%0d expected 9 4 0 0 0",
               h, v, upd_req, overrun, frame_cnt);
    end
  endtask

  task automatic test_frame_wrap();
    en2 = 1'b1;
    repeat (65535) @(negedge clk);
    vectors++;
    if ({frame2, h2, v2} !== {16'hFFFF, 15'd0, 15'd0}) begin
      miscompares++; $display("FAIL frame_max: got frame=%0d h=%0d v=%0d expected 65535 0 0", frame2, h2, v2);
    end
    vectors++;
    if ({pix_ce2, upd_req2, overrun2} !== 3'b111) begin
      miscompares++; $display("FAIL tiny_flags_odd: got %b expected 111", {pix_ce2, upd_req2, overrun2});
    end
    @(negedge clk);
    vectors++;
    if (frame2 !== 16'd0) begin
      miscompares++; $display("FAIL frame_wrap: got %0d expected 0", frame2);
    end
    vectors++;
    if ({pix_ce2, upd_req2, overrun2} !== 3'b101) begin
      miscompares++; $display("FAIL tiny_flags_even: got %b expected 101", {pix_ce2, upd_req2, overrun2});
    end
    en2 = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_pix_strobe();
    test_req_handshake();
    test_overrun();
    test_done_on_wrap();
    test_en_low();
    test_reset_mid_req();
    test_frame_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
